// File: rtl/gray_arb_pkg.sv
// Shared types and the round-robin pick function for gray_conv_arbiter.
// Supports up to MAX_REQ requesters; callers zero-extend narrower vectors.
package gray_arb_pkg;

    localparam int unsigned MAX_REQ = 16;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } rr_pick_t;

    // Search starts just after 'last' and wraps modulo num_req; first valid wins.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [3:0]         last,
                                         input int unsigned        num_req);
        rr_pick_t   res;
        logic [3:0] idx;
        res = '0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            idx = 4'((32'(last) + k) % num_req);
            if (k <= num_req && !res.hit && valid[idx]) begin
                res.hit = 1'b1;
                res.idx = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/binary_to_gray.sv
// Combinational binary-to-Gray converter; MSB passes through unchanged.
module binary_to_gray #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] bin,
    output logic [DATA_WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one binary_to_gray converter among NUM_REQ requesters,
// with a single registered valid/ready output stage tagged by winner ID.
module gray_conv_arbiter
    import gray_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REQ    = 4,
    localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [ID_W-1:0]               out_id,
    output logic                          busy
);

    state_e                state;
    logic [ID_W-1:0]       last_grant;
    logic [MAX_REQ-1:0]    valid_ext;
    logic [3:0]            last_ext;
    rr_pick_t              pick;
    logic [ID_W-1:0]       winner;
    logic                  accept;
    logic [DATA_WIDTH-1:0] win_data;
    logic [DATA_WIDTH-1:0] win_gray;
    logic                  unused_idx;

    always_comb begin
        valid_ext = '0;
        valid_ext[NUM_REQ-1:0] = req_valid;
        last_ext = '0;
        last_ext[ID_W-1:0] = last_grant;
    end

    assign pick       = rr_pick(valid_ext, last_ext, NUM_REQ);
    assign winner     = pick.idx[ID_W-1:0];
    assign unused_idx = ^pick.idx;
    // The output slot is free when empty or being drained this cycle.
    assign accept     = pick.hit && (state == ST_EMPTY || out_ready);

    always_comb begin
        win_data  = '0;
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                win_data     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                req_ready[i] = accept;
            end
        end
    end

    binary_to_gray #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_b2g (
        .bin (win_data),
        .gray(win_gray)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            out_data   <= '0;
            out_id     <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else if (accept) begin
            state      <= ST_FULL;
            out_data   <= win_gray;
            out_id     <= winner;
            last_grant <= winner;
        end else if (state == ST_FULL && out_ready) begin
            state <= ST_EMPTY;
        end
    end

    assign out_valid = (state == ST_FULL);
    assign busy      = out_valid || (|req_valid);

endmodule
